serial_twos_complement_converter: RTL and testbench
===================================================

Name: serial_twos_complement_converter

Overview:
- Bit-serial, handshaked successor to the fixed 5-bit 2's complement lookup used in the partial-product adder path.
- Accepts one operand per transaction, either an unsigned binary magnitude or a thermometer code, each with a sign flag.
- Negates LSB-first with the serial "copy through first 1, invert after" rule.
- Returns a WIDTH-bit 2's complement word with overflow and code-error flags. Sits between the thermometer front end and the partial-product adder.

Parameters:
- WIDTH, 5, result width in bits (>=2).
- THERM_W, 2**WIDTH-1, thermometer input width. Legal range 1..2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand presented
- in_ready  output  1  block can accept (IDLE only)
- in_mode  input  1  0 = binary magnitude on in_bin; 1 = thermometer code on in_therm
- in_neg  input  1  1 = output the negated magnitude
- in_bin  input  WIDTH  unsigned magnitude (mode 0)
- in_therm  input  THERM_W  thermometer code, ones packed from bit 0 (mode 1)
- out_valid  output  1  result held
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  2's complement result
- out_ovf  output  1  signed result not representable in WIDTH bits
- out_err  output  1  thermometer code not contiguous from bit 0 (mode 1 only)
- busy  output  1  state != IDLE

Behaviour:
- Reset, async while rst=1:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, out_err=0, busy=0.
  - Bit counter and shift registers cleared.
  - Reset mid-transaction drops it; no partial result is ever presented.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1. On in_valid at an edge, capture the operand and go to SHIFT with bit_cnt=0 and seen_one=0.
  - Captured magnitude mag (WIDTH+1 bits internal):
    - mode 0: mag = in_bin.
    - mode 1: mag = popcount(in_therm), combinational at capture.
  - err = mode1 AND in_therm is not of the form 0..01..1 (all-zero is legal).
  - in_neg is captured alongside.
- SHIFT, one bit per cycle, LSB first, for exactly WIDTH cycles:
  - b = mag[bit_cnt].
  - If neg=0, out bit = b.
  - If neg=1, out bit = seen_one ? ~b : b; seen_one is set when b=1.
  - The result bit shifts into out_data from the MSB side, so after WIDTH shifts bit i is in position i.
  - bit_cnt==WIDTH-1 -> DONE.
- DONE:
  - out_valid=1. out_data, out_ovf and out_err are stable until the handshake.
  - out_valid AND out_ready at an edge -> IDLE, out_valid=0.
  - out_data keeps its last value after the handshake.
- Latency: out_valid rises exactly WIDTH+1 edges after the accept edge. Throughput is one operand per WIDTH+2 cycles minimum.
- No accept while busy: in_ready=0 in SHIFT and DONE, and in_valid is ignored there.
- Overflow, computed on the full-precision mag:
  - neg=0: out_ovf = (mag >= 2**(WIDTH-1)).
  - neg=1: out_ovf = (mag > 2**(WIDTH-1)).
  - out_data is always mag negated mod 2**WIDTH, or mag mod 2**WIDTH when not negated.
- Boundaries:
  - Negating 0 gives 0 (seen_one never sets), ovf=0.
  - Negating 2**(WIDTH-1) gives 1 followed by WIDTH-1 zeros, ovf=0.
  - Thermometer all-ones with THERM_W=2**WIDTH-1 gives mag=2**WIDTH-1.
- Error handling: out_err=1 does not alter the datapath; the result is still popcount-based. out_err=0 always in mode 0.
- All outputs are registered except in_ready and busy, which decode state.

Test Plan:
- WIDTH=5; mode0, bin=5'd3, neg=1 -> out_data=5'b11101, ovf=0, err=0. out_valid rises 6 edges after accept.
- Mode0 with neg=1 across all mag 0..31 -> out_data=(32-mag)%32. 0->0 ovf=0; 16->5'b10000 ovf=0; 17->5'b01111 ovf=1. Neg=0 with mag=16 -> ovf=1.
- Mode1, therm=31'h0000_00FF, neg=1 -> mag=8, out_data=5'b11000, err=0. Therm=31'h0000_0105 -> err=1, out_data=(32-3)%32=5'b11101.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid, data and flags stable; in_ready=0 and in_valid ignored throughout. Release -> IDLE next edge, in_ready=1.
- Assert rst for 1 cycle during SHIFT at bit_cnt=2 -> all outputs at reset values immediately. The next operand, bin=5'd1 neg=1, returns 5'b11111 with normal latency.
- Back-to-back: hold in_valid=1 and out_ready=1 with two operands -> second accepted exactly WIDTH+2 edges after the first; both results correct.

Source files
------------

// File: rtl/serial_twos_complement_converter_if.sv
// Operand/result handshake bundle for the bit-serial 2's complement converter.
// The master side presents operands and consumes results; the slave side is the converter.
interface serial_twos_complement_converter_if #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned THERM_W = 2**WIDTH - 1
);
    logic               in_valid;
    logic               in_ready;
    logic               in_mode;
    logic               in_neg;
    logic [WIDTH-1:0]   in_bin;
    logic [THERM_W-1:0] in_therm;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_ovf;
    logic               out_err;

    modport master (
        output in_valid, in_mode, in_neg, in_bin, in_therm, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_mode, in_neg, in_bin, in_therm, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_err
    );
endinterface

// File: rtl/serial_twos_complement_converter.sv
// Bit-serial 2's complement converter: captures a binary or thermometer magnitude and
// negates it LSB-first ("copy through first 1, invert after"), WIDTH bits per operand.
module serial_twos_complement_converter #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned THERM_W = 2**WIDTH - 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    serial_twos_complement_converter_if.slave      bus,
    output logic                                   busy
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0]  Half    = (WIDTH+1)'(2**(WIDTH-1));
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH-1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q;
    logic [WIDTH:0]     mag_q;
    logic [CntW-1:0]    cnt_q;
    logic               neg_q;
    logic               seen_q;
    logic               ovf_q;
    logic               err_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_ovf_q;
    logic               out_err_q;

    logic [WIDTH:0]     therm_cnt;
    logic [THERM_W-1:0] therm_inc;
    logic               therm_bad;
    logic [WIDTH:0]     cap_mag;
    logic               cap_ovf;
    logic               out_bit;

    always_comb begin
        therm_cnt = '0;
        for (int i = 0; i < THERM_W; i++) begin
            therm_cnt = therm_cnt + (WIDTH+1)'(bus.in_therm[i]);
        end
    end

    // A legal code 0..01..1 plus one has no bit in common with itself.
    assign therm_inc = bus.in_therm + THERM_W'(1);
    assign therm_bad = |(bus.in_therm & therm_inc);

    assign cap_mag = bus.in_mode ? therm_cnt : {1'b0, bus.in_bin};
    assign cap_ovf = bus.in_neg ? (cap_mag > Half) : (cap_mag >= Half);

    assign out_bit = (neg_q && seen_q) ? ~mag_q[0] : mag_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mag_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            seen_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        mag_q   <= cap_mag;
                        neg_q   <= bus.in_neg;
                        seen_q  <= 1'b0;
                        cnt_q   <= '0;
                        ovf_q   <= cap_ovf;
                        err_q   <= bus.in_mode & therm_bad;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    // Result enters at the MSB so the first (LSB) bit ends up in position 0.
                    out_data_q <= {out_bit, out_data_q[WIDTH-1:1]};
                    mag_q      <= mag_q >> 1;
                    seen_q     <= seen_q | mag_q[0];
                    cnt_q      <= cnt_q + CntW'(1);
                    if (cnt_q == LastBit) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        out_ovf_q   <= ovf_q;
                        out_err_q   <= err_q;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_serial_twos_complement_converter.sv
// Self-checking bench for serial_twos_complement_converter: fixed vectors, sweeps,
// random operands against an arithmetic model, and handshake/reset corner sequences.
module tb_serial_twos_complement_converter;
    localparam int unsigned W  = 5;
    localparam int unsigned TW = 2**W - 1;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    serial_twos_complement_converter_if #(.WIDTH(W), .THERM_W(TW)) bus ();

    serial_twos_complement_converter #(.WIDTH(W), .THERM_W(TW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          mode;
        logic          neg;
        logic [W-1:0]  bin;
        logic [TW-1:0] therm;
        logic [W-1:0]  data;
        logic          ovf;
        logic          err;
    } vec_t;

    // Reference: plain arithmetic on the magnitude, no bit-serial mechanics.
    function automatic vec_t model(input logic mode, input logic neg, input logic [W-1:0] bin,
                                   input logic [TW-1:0] therm);
        vec_t        r;
        int          mag;
        logic [63:0] full;
        mag     = mode ? $countones(therm) : int'(bin);
        r.mode  = mode;
        r.neg   = neg;
        r.bin   = bin;
        r.therm = therm;
        r.data  = W'(neg ? ((2**W - mag) % (2**W)) : (mag % (2**W)));
        r.ovf   = neg ? (mag > 2**(W-1)) : (mag >= 2**(W-1));
        full    = (64'd1 << mag) - 64'd1;
        r.err   = mode && (64'(therm) != full);
        return r;
    endfunction

    // Entered at a negedge with the DUT idle; leaves at a negedge after the handshake.
    task automatic run_txn(input logic mode, input logic neg, input logic [W-1:0] bin,
                           input logic [TW-1:0] therm, output logic [W-1:0] d,
                           output logic o, output logic e, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_mode  = mode;
        bus.in_neg   = neg;
        bus.in_bin   = bin;
        bus.in_therm = therm;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_mode  = 1'($urandom);
        bus.in_neg   = 1'($urandom);
        bus.in_bin   = W'($urandom);
        bus.in_therm = TW'($urandom);
        lat = 1;  // the accept edge counts as edge 1
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
        d = bus.out_data;
        o = bus.out_ovf;
        e = bus.out_err;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_after_handshake", 32'({bus.out_valid, bus.in_ready, busy}), 32'b010);
    endtask

    vec_t          vecs[12];
    vec_t          exp_v;
    logic [W-1:0]  d;
    logic          o;
    logic          e;
    int            lat;
    logic [TW-1:0] th;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_neg    = 1'b0;
        bus.in_bin    = '0;
        bus.in_therm  = '0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{1'b0, 1'b1, 5'd3,  31'h0000_0105, 5'b11101, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 5'd0,  31'h0,         5'b00000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 5'd16, 31'h0,         5'b10000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 5'd17, 31'h0,         5'b01111, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 5'd16, 31'h0,         5'b10000, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 5'd15, 31'h0,         5'b01111, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 5'd0,  31'h0000_00FF, 5'b11000, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 5'd0,  31'h0000_0105, 5'b11101, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 5'd0,  31'h7FFF_FFFF, 5'b11111, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 5'd0,  31'h0,         5'b00000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 5'd0,  31'h7FFF_FFFF, 5'b00001, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'd31, 31'h0,         5'b11111, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_state",
              32'({bus.out_valid, bus.out_data, bus.out_ovf, bus.out_err, bus.in_ready, busy}),
              32'b0_00000_0_0_1_0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].mode, vecs[i].neg, vecs[i].bin, vecs[i].therm, d, o, e, lat);
            check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].data));
            check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
        end

        for (int m = 0; m < 2**W; m++) begin
            exp_v = model(1'b0, 1'b1, W'(m), '0);
            run_txn(1'b0, 1'b1, W'(m), TW'($urandom), d, o, e, lat);
            check($sformatf("neg_sweep%0d_data", m), 32'(d), 32'(exp_v.data));
            check($sformatf("neg_sweep%0d_ovf", m), 32'(o), 32'(exp_v.ovf));
            check($sformatf("neg_sweep%0d_err", m), 32'(e), 32'(exp_v.err));
        end

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1)
                th = TW'((64'd1 << $urandom_range(0, TW)) - 64'd1);
            else
                th = TW'($urandom);
            exp_v = model(1'($urandom), 1'($urandom), W'($urandom), th);
            run_txn(exp_v.mode, exp_v.neg, exp_v.bin, exp_v.therm, d, o, e, lat);
            check($sformatf("rand%0d_data", k), 32'(d), 32'(exp_v.data));
            check($sformatf("rand%0d_ovf", k), 32'(o), 32'(exp_v.ovf));
            check($sformatf("rand%0d_err", k), 32'(e), 32'(exp_v.err));
        end

        // Backpressure: result must hold while a competing operand is offered.
        exp_v = model(1'b0, 1'b1, 5'd20, '0);
        bus.in_mode  = 1'b0;
        bus.in_neg   = 1'b1;
        bus.in_bin   = 5'd20;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_neg = 1'b0;
        bus.in_bin = 5'd7;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d_hold", c),
                  32'({bus.out_valid, bus.out_data, bus.out_ovf, bus.out_err, bus.in_ready, busy}),
                  32'({1'b1, exp_v.data, exp_v.ovf, exp_v.err, 1'b0, 1'b1}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release", 32'({bus.out_valid, bus.in_ready, busy}), 32'b010);
        check("bp_data_kept", 32'(bus.out_data), 32'(exp_v.data));
        @(posedge clk);
        @(negedge clk);
        check("bp_still_idle", 32'({bus.in_ready, busy}), 32'b10);

        // Reset while shifting at bit_cnt == 2.
        bus.in_mode  = 1'b0;
        bus.in_neg   = 1'b0;
        bus.in_bin   = 5'd9;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midreset_outputs",
              32'({bus.out_valid, bus.out_data, bus.out_ovf, bus.out_err, bus.in_ready, busy}),
              32'b0_00000_0_0_1_0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(1'b0, 1'b1, 5'd1, '0, d, o, e, lat);
        check("post_reset_data", 32'(d), 32'(5'b11111));
        check("post_reset_flags", 32'({o, e}), 32'b00);
        check("post_reset_latency", 32'(lat), 32'(W + 1));

        // Back-to-back with in_valid and out_ready held high.
        begin
            int           acc_edge[2];
            int           naccept;
            int           nres;
            logic [W-1:0] res_data[2];
            logic         res_ovf[2];
            logic         res_err[2];
            logic         acc;
            vec_t         exp_b;
            exp_v = model(1'b0, 1'b1, 5'd6, '0);
            exp_b = model(1'b1, 1'b0, 5'd0, 31'h0000_0007);
            acc_edge[0] = 0;
            acc_edge[1] = 0;
            naccept = 0;
            nres = 0;
            bus.in_mode   = exp_v.mode;
            bus.in_neg    = exp_v.neg;
            bus.in_bin    = exp_v.bin;
            bus.in_therm  = exp_v.therm;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            for (int c = 1; c <= 30; c++) begin
                acc = bus.in_ready && bus.in_valid;
                if (bus.out_valid && nres < 2) begin
                    res_data[nres] = bus.out_data;
                    res_ovf[nres]  = bus.out_ovf;
                    res_err[nres]  = bus.out_err;
                    nres++;
                end
                @(posedge clk);
                @(negedge clk);
                if (acc && naccept < 2) begin
                    acc_edge[naccept] = c;
                    naccept++;
                    if (naccept == 1) begin
                        bus.in_mode  = exp_b.mode;
                        bus.in_neg   = exp_b.neg;
                        bus.in_bin   = exp_b.bin;
                        bus.in_therm = exp_b.therm;
                    end else begin
                        bus.in_valid = 1'b0;
                    end
                end
            end
            bus.out_ready = 1'b0;
            check("b2b_accepts", 32'(naccept), 32'd2);
            check("b2b_results", 32'(nres), 32'd2);
            if (naccept == 2)
                check("b2b_spacing", 32'(acc_edge[1] - acc_edge[0]), 32'(W + 2));
            if (nres == 2) begin
                check("b2b_a_data", 32'(res_data[0]), 32'(exp_v.data));
                check("b2b_a_flags", 32'({res_ovf[0], res_err[0]}), 32'({exp_v.ovf, exp_v.err}));
                check("b2b_b_data", 32'(res_data[1]), 32'(exp_b.data));
                check("b2b_b_flags", 32'({res_ovf[1], res_err[1]}), 32'({exp_b.ovf, exp_b.err}));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
